mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arbiter_rr_arbiter2.sv | 42 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encodings, requester IDs, default widths and the round-robin pick rule.
package mem_arbiter_pkg;

  // Default line address and data widths.
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  // Transaction FSM: accept a request, present it to memory, await read data.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Requester identifiers; IC is the reset value of last_grant so DC wins the first tie.
  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  // Two-way round-robin pick: a lone requester wins, a tie goes to the one
  // that was not granted last. With nothing valid the result is don't-care.
  function automatic req_id_t rr_pick(input logic ic_valid, input logic dc_valid,
                                      input req_id_t last_grant);
    req_id_t pick;
    if (ic_valid && dc_valid) begin
      pick = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (dc_valid) begin
      pick = REQ_DC;
    end else begin
      pick = REQ_IC;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. Grants are combinational from the valids and
// the enable; the last_grant register advances only when a grant is given.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic ic_valid,
  input  logic dc_valid,
  output logic grant_ic,
  output logic grant_dc
);

  req_id_t last_grant;
  req_id_t winner;

  // Pick the winner and gate the grants with the enable.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the block
    // leaves it unassigned and no latch is inferred.
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    winner   = rr_pick(ic_valid, dc_valid, last_grant);
    if (enable) begin
      grant_ic = ic_valid && (winner == REQ_IC);
      grant_dc = dc_valid && (winner == REQ_DC);
    end
  end

  // Remember who was granted most recently for the next tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= REQ_IC;
    end else if (grant_dc) begin
      last_grant <= REQ_DC;
    end else if (grant_ic) begin
      last_grant <= REQ_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one memory request/response channel between an
// ICache (read-only) and a DCache (read/write). One transaction at a time;
// writes are posted, reads return data on the shared resp_data register.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,

  input  logic              dc_req_valid,
  input  logic              dc_req_rnw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_wdata,
  input  logic [MASK_W-1:0] dc_req_wmask,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,

  output logic [DATA_W-1:0] resp_data,

  output logic              mem_req_valid,
  output logic              mem_req_rnw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  state_t  state;
  req_id_t owner;
  logic    grant_ic;
  logic    grant_dc;
  logic    accept;

  // Grants are only offered while idle, which keeps both readies low elsewhere.
  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (state == ST_IDLE),
    .ic_valid (ic_req_valid),
    .dc_valid (dc_req_valid),
    .grant_ic (grant_ic),
    .grant_dc (grant_dc)
  );

  // Ready is the grant itself, so it is visible in the same cycle as the request.
  assign ic_req_ready = grant_ic;
  assign dc_req_ready = grant_dc;
  assign accept       = grant_ic | grant_dc;

  // Transaction FSM with registered memory-request fields and response pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      owner         <= REQ_IC;
      mem_req_valid <= 1'b0;
      mem_req_rnw   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      resp_data     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge register values regardless of statement order.
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_ISSUE;
            mem_req_valid <= 1'b1;
            if (grant_dc) begin
              owner         <= REQ_DC;
              mem_req_rnw   <= dc_req_rnw;
              mem_req_addr  <= dc_req_addr;
              mem_req_wdata <= dc_req_wdata;
              mem_req_wmask <= dc_req_wmask;
            end else begin
              // ICache only reads; write fields are zeroed for a clean bus.
              owner         <= REQ_IC;
              mem_req_rnw   <= 1'b1;
              mem_req_addr  <= ic_req_addr;
              mem_req_wdata <= '0;
              mem_req_wmask <= '0;
            end
          end
        end

        ST_ISSUE: begin
          // Fields stay untouched here, so they are stable until the handshake.
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= mem_req_rnw ? ST_WAIT : ST_IDLE;
          end
        end

        ST_WAIT: begin
          // Only here is mem_resp_valid honoured; elsewhere it is ignored.
          if (mem_resp_valid) begin
            resp_data     <= mem_resp_data;
            ic_resp_valid <= (owner == REQ_IC);
            dc_resp_valid <= (owner == REQ_DC);
            state         <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: IC read latency, spurious responses,
// reset during WAIT, round-robin order with back-to-back grants, and a
// back-pressured posted DC write.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int W      = DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic              dc_req_valid;
  logic              dc_req_rnw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_wdata;
  logic [MASK_W-1:0] dc_req_wmask;
  logic              dc_req_ready;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              mem_req_valid;
  logic              mem_req_rnw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .dc_req_valid   (dc_req_valid),
    .dc_req_rnw     (dc_req_rnw),
    .dc_req_addr    (dc_req_addr),
    .dc_req_wdata   (dc_req_wdata),
    .dc_req_wmask   (dc_req_wmask),
    .dc_req_ready   (dc_req_ready),
    .dc_resp_valid  (dc_resp_valid),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rnw    (mem_req_rnw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_5A = {16{8'h5A}};
  localparam logic [DATA_W-1:0] WDATA  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, still well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    ic_req_valid   = 1'b0;
    ic_req_addr    = '0;
    dc_req_valid   = 1'b0;
    dc_req_rnw     = 1'b1;
    dc_req_addr    = '0;
    dc_req_wdata   = '0;
    dc_req_wmask   = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    settle();
  endtask

  task automatic check_no_pulse(input string tag);
    check({tag, "_ic_resp"}, W'(ic_resp_valid), W'(1'b0));
    check({tag, "_dc_resp"}, W'(dc_resp_valid), W'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    apply_reset();
    check("rst_mem_req_valid", W'(mem_req_valid), W'(1'b0));
    check("rst_mem_req_rnw",   W'(mem_req_rnw),   W'(1'b0));
    check("rst_mem_req_addr",  W'(mem_req_addr),  W'(0));
    check("rst_mem_req_wdata", W'(mem_req_wdata), W'(0));
    check("rst_mem_req_wmask", W'(mem_req_wmask), W'(0));
    check("rst_resp_data",     W'(resp_data),     W'(0));
    check("rst_ic_ready",      W'(ic_req_ready),  W'(1'b0));
    check("rst_dc_ready",      W'(dc_req_ready),  W'(1'b0));
    check_no_pulse("rst");

    // ---------------- lone IC read, response 3 cycles after issue ----------------
    mem_req_ready = 1'b1;
    ic_req_valid  = 1'b1;
    ic_req_addr   = 28'h0000123;
    settle();
    check("ic_ready_idle", W'(ic_req_ready), W'(1'b1));
    check("ic_dc_ready_low", W'(dc_req_ready), W'(1'b0));
    tick();                               // accept edge; now ISSUE
    ic_req_valid = 1'b0;
    settle();
    check("ic_issue_valid", W'(mem_req_valid), W'(1'b1));
    check("ic_issue_addr",  W'(mem_req_addr),  W'(28'h0000123));
    check("ic_issue_rnw",   W'(mem_req_rnw),   W'(1'b1));
    check("ic_issue_wdata", W'(mem_req_wdata), W'(0));
    check("ic_issue_wmask", W'(mem_req_wmask), W'(0));
    tick();                               // handshake; now WAIT
    settle();
    check("ic_wait_valid_low", W'(mem_req_valid), W'(1'b0));
    check_no_pulse("ic_wait1");
    tick();
    settle();
    check_no_pulse("ic_wait2");
    tick();
    mem_resp_valid = 1'b1;                // third cycle after issue
    mem_resp_data  = PAT_A5;
    settle();
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    settle();
    check("ic_resp_pulse",  W'(ic_resp_valid), W'(1'b1));
    check("ic_dc_resp_low", W'(dc_resp_valid), W'(1'b0));
    check("ic_resp_data",   resp_data,         PAT_A5);
    tick();
    settle();
    check_no_pulse("ic_after_pulse");
    check("ic_resp_data_hold", resp_data, PAT_A5);

    // ---------------- spurious mem_resp_valid in IDLE and ISSUE ----------------
    mem_resp_valid = 1'b1;
    mem_resp_data  = PAT_5A;
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check_no_pulse("spur_idle");
    check("spur_idle_data", resp_data, PAT_A5);
    mem_req_ready = 1'b0;
    ic_req_valid  = 1'b1;
    ic_req_addr   = 28'h0000200;
    settle();
    tick();                               // accepted; now ISSUE
    ic_req_valid   = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = PAT_5A;
    settle();
    check("spur_issue_valid", W'(mem_req_valid), W'(1'b1));
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check_no_pulse("spur_issue");
    check("spur_issue_data", resp_data, PAT_A5);
    check("spur_still_issue", W'(mem_req_valid), W'(1'b1));
    mem_req_ready = 1'b1;
    tick();                               // now WAIT
    mem_resp_valid = 1'b1;
    mem_resp_data  = W'(128'h77);
    settle();
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("spur_real_pulse", W'(ic_resp_valid), W'(1'b1));
    check("spur_real_data",  resp_data,         W'(128'h77));

    // ---------------- reset while in WAIT ----------------
    dc_req_valid = 1'b1;
    dc_req_rnw   = 1'b1;
    dc_req_addr  = 28'h0000044;
    settle();
    check("rw_dc_ready", W'(dc_req_ready), W'(1'b1));
    tick();                               // ISSUE
    dc_req_valid = 1'b0;
    settle();
    check("rw_issue_addr", W'(mem_req_addr), W'(28'h0000044));
    tick();                               // WAIT
    settle();
    reset_n = 1'b0;
    #1;
    check("rw_rst_valid", W'(mem_req_valid), W'(1'b0));
    check("rw_rst_addr",  W'(mem_req_addr),  W'(0));
    check("rw_rst_rnw",   W'(mem_req_rnw),   W'(1'b0));
    check("rw_rst_data",  resp_data,         W'(0));
    tick();
    reset_n        = 1'b1;
    mem_resp_valid = 1'b1;                // late response must be dropped
    mem_resp_data  = W'(128'h99);
    settle();
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check_no_pulse("rw_late");
    check("rw_late_data", resp_data, W'(0));
    dc_req_valid = 1'b1;
    dc_req_addr  = 28'h0000055;
    settle();
    check("rw_next_ready", W'(dc_req_ready), W'(1'b1));
    tick();
    dc_req_valid = 1'b0;
    settle();
    check("rw_next_addr", W'(mem_req_addr), W'(28'h0000055));
    tick();                               // WAIT
    mem_resp_valid = 1'b1;
    mem_resp_data  = W'(128'h1234);
    settle();
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("rw_next_dc_pulse", W'(dc_resp_valid), W'(1'b1));
    check("rw_next_ic_low",   W'(ic_resp_valid), W'(1'b0));
    check("rw_next_data",     resp_data,         W'(128'h1234));

    // ---------------- round robin, both valid every cycle ----------------
    apply_reset();
    mem_req_ready = 1'b1;
    ic_req_valid  = 1'b1;
    ic_req_addr   = 28'h0000111;
    dc_req_valid  = 1'b1;
    dc_req_rnw    = 1'b1;
    dc_req_addr   = 28'h0000222;
    settle();
    for (int i = 0; i < 4; i++) begin
      logic exp_dc;
      exp_dc = (i % 2 == 0);
      check($sformatf("rr%0d_dc_ready", i), W'(dc_req_ready), W'(exp_dc));
      check($sformatf("rr%0d_ic_ready", i), W'(ic_req_ready), W'(!exp_dc));
      tick();                             // ISSUE
      settle();
      check($sformatf("rr%0d_issue_readies", i), W'({ic_req_ready, dc_req_ready}), W'(2'b00));
      check($sformatf("rr%0d_addr", i), W'(mem_req_addr),
            exp_dc ? W'(28'h0000222) : W'(28'h0000111));
      tick();                             // WAIT
      mem_resp_valid = 1'b1;
      mem_resp_data  = W'(i + 1);
      settle();
      check($sformatf("rr%0d_wait_readies", i), W'({ic_req_ready, dc_req_ready}), W'(2'b00));
      tick();                             // IDLE with response pulse
      mem_resp_valid = 1'b0;
      settle();
      check($sformatf("rr%0d_dc_pulse", i), W'(dc_resp_valid), W'(exp_dc));
      check($sformatf("rr%0d_ic_pulse", i), W'(ic_resp_valid), W'(!exp_dc));
      check($sformatf("rr%0d_data", i), resp_data, W'(i + 1));
      if (i == 1) begin
        check("resp_with_new_grant", W'({dc_req_ready, ic_resp_valid}), W'(2'b11));
      end
    end

    // ---------------- back-pressured posted DC write ----------------
    apply_reset();
    mem_req_ready = 1'b0;
    dc_req_valid  = 1'b1;
    dc_req_rnw    = 1'b0;
    dc_req_addr   = 28'h0000010;
    dc_req_wdata  = WDATA;
    dc_req_wmask  = 16'h000F;
    settle();
    check("wr_dc_ready", W'(dc_req_ready), W'(1'b1));
    tick();                               // ISSUE
    dc_req_valid = 1'b0;
    dc_req_wdata = '0;
    dc_req_wmask = '0;
    dc_req_addr  = '0;
    for (int c = 0; c < 5; c++) begin
      settle();
      check($sformatf("wr_stall%0d_valid", c), W'(mem_req_valid), W'(1'b1));
      check($sformatf("wr_stall%0d_rnw", c),   W'(mem_req_rnw),   W'(1'b0));
      check($sformatf("wr_stall%0d_addr", c),  W'(mem_req_addr),  W'(28'h0000010));
      check($sformatf("wr_stall%0d_wdata", c), mem_req_wdata,     WDATA);
      check($sformatf("wr_stall%0d_wmask", c), W'(mem_req_wmask), W'(16'h000F));
      tick();
    end
    mem_req_ready = 1'b1;
    settle();
    check("wr_hs_valid", W'(mem_req_valid), W'(1'b1));
    tick();                               // handshake done; back to IDLE
    settle();
    check("wr_post_valid", W'(mem_req_valid), W'(1'b0));
    check_no_pulse("wr_post");
    ic_req_valid = 1'b1;
    ic_req_addr  = 28'h0000333;
    #1;
    check("wr_back_idle", W'(ic_req_ready), W'(1'b1));
    ic_req_valid = 1'b0;
    tick();
    settle();
    check_no_pulse("wr_post2");
    check("wr_post2_valid", W'(mem_req_valid), W'(1'b0));
    check("wr_resp_data_hold", resp_data, W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
